// File: rtl/instr_encoder.sv
// RV32I I/B-type instruction encoder and program loader.
// Define INSTR_ENC_READBACK_EN to add a readback VERIFY state.
module instr_encoder #(
  parameter int DATA_WIDTH = 32,
  parameter int IMM_WIDTH  = 12,
  parameter int ADDR_WIDTH = 8,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  restart,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  fmt,
  input  logic [6:0]            opcode,
  input  logic [2:0]            funct3,
  input  logic [4:0]            rd,
  input  logic [4:0]            rs1,
  input  logic [4:0]            rs2,
  input  logic [DATA_WIDTH-1:0] imm,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  err,
  output logic                  full,
  output logic                  rb_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ENCODE,
    S_WRITE,
    S_VERIFY
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] ADDR_BASE = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;

  localparam logic signed [DATA_WIDTH-1:0] I_MIN =
    DATA_WIDTH'(-(2 ** (IMM_WIDTH - 1)));
  localparam logic signed [DATA_WIDTH-1:0] I_MAX =
    DATA_WIDTH'((2 ** (IMM_WIDTH - 1)) - 1);
  localparam logic signed [DATA_WIDTH-1:0] B_MIN =
    DATA_WIDTH'(-(2 ** IMM_WIDTH));
  localparam logic signed [DATA_WIDTH-1:0] B_MAX =
    DATA_WIDTH'((2 ** IMM_WIDTH) - 2);

  state_e                  state_q, state_d;
  logic                    fmt_q;
  logic [6:0]              op_q;
  logic [2:0]              f3_q;
  logic [4:0]              rd_q, rs1_q, rs2_q;
  logic [DATA_WIDTH-1:0]   imm_q;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    err_q, err_d;
  logic                    full_q, full_d;

  logic                    hs;
  logic                    i_ok, b_ok, imm_ok;
  logic signed [DATA_WIDTH-1:0] imm_s;
  logic [DATA_WIDTH-1:0]   i_word, b_word;

  assign in_ready = (state_q == S_IDLE) && !full_q;
  assign hs       = in_valid && in_ready;
  assign wr_en    = (state_q == S_WRITE) && !restart;
  assign wr_addr  = addr_q;
  assign wr_data  = data_q;
  assign err      = err_q;
  assign full     = full_q;

  assign imm_s  = $signed(imm_q);
  assign i_ok   = (imm_s >= I_MIN) && (imm_s <= I_MAX);
  assign b_ok   = (imm_s >= B_MIN) && (imm_s <= B_MAX) && !imm_q[0];
  assign imm_ok = fmt_q ? b_ok : i_ok;

  assign i_word = {imm_q[11:0], rs1_q, f3_q, rd_q, op_q};
  assign b_word = {imm_q[12], imm_q[10:5], rs2_q, rs1_q,
                   f3_q, imm_q[4:1], imm_q[11], op_q};

`ifdef INSTR_ENC_READBACK_EN
  logic                  rb_err_q, rb_err_d;
  logic [DATA_WIDTH-1:0] rb_imm;

  assign rb_err = rb_err_q;

  // Re-extract the immediate the way the datapath will see it.
  always_comb begin
    rb_imm = '0;
    if (fmt_q) begin
      rb_imm = {{(DATA_WIDTH-12){data_q[31]}}, data_q[7],
                data_q[30:25], data_q[11:8], 1'b0};
    end else begin
      rb_imm = {{(DATA_WIDTH-12){data_q[31]}}, data_q[31:20]};
    end
  end
`else
  assign rb_err = 1'b0;
`endif

  // Next-state, address, word and sticky-flag logic.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    err_d   = err_q;
    full_d  = full_q;
`ifdef INSTR_ENC_READBACK_EN
    rb_err_d = rb_err_q;
`endif
    if (restart) begin
      state_d = S_IDLE;
      addr_d  = ADDR_BASE;
      err_d   = 1'b0;
      full_d  = 1'b0;
`ifdef INSTR_ENC_READBACK_EN
      rb_err_d = 1'b0;
`endif
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (hs) state_d = S_ENCODE;
        end
        S_ENCODE: begin
          if (imm_ok) begin
            data_d  = fmt_q ? b_word : i_word;
            state_d = S_WRITE;
          end else begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
        S_WRITE: begin
          if (addr_q == ADDR_LAST) full_d = 1'b1;
          else                     addr_d = addr_q + 1'b1;
`ifdef INSTR_ENC_READBACK_EN
          state_d = S_VERIFY;
`else
          state_d = S_IDLE;
`endif
        end
`ifdef INSTR_ENC_READBACK_EN
        S_VERIFY: begin
          if (rb_imm != imm_q) rb_err_d = 1'b1;
          state_d = S_IDLE;
        end
`endif
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State, address, word and flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= ADDR_BASE;
      data_q  <= '0;
      err_q   <= 1'b0;
      full_q  <= 1'b0;
`ifdef INSTR_ENC_READBACK_EN
      rb_err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      err_q   <= err_d;
      full_q  <= full_d;
`ifdef INSTR_ENC_READBACK_EN
      rb_err_q <= rb_err_d;
`endif
    end
  end

  // Capture request fields on handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      fmt_q <= 1'b0;
      op_q  <= '0;
      f3_q  <= '0;
      rd_q  <= '0;
      rs1_q <= '0;
      rs2_q <= '0;
      imm_q <= '0;
    end else if (hs && !restart) begin
      fmt_q <= fmt;
      op_q  <= opcode;
      f3_q  <= funct3;
      rd_q  <= rd;
      rs1_q <= rs1;
      rs2_q <= rs2;
      imm_q <= imm;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder.
// Runs with ADDR_WIDTH=2 so the full/no-wrap path is reachable.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst, restart, in_valid, in_ready;
  logic        fmt;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm;
  logic        wr_en;
  logic [1:0]  wr_addr;
  logic [31:0] wr_data;
  logic        err, full, rb_err;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef INSTR_ENC_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  localparam logic [6:0] OP_I = 7'b0010011;
  localparam logic [6:0] OP_B = 7'b1100011;

  instr_encoder #(
    .DATA_WIDTH(32),
    .IMM_WIDTH (12),
    .ADDR_WIDTH(2),
    .BASE_ADDR (0)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .fmt     (fmt),
    .opcode  (opcode),
    .funct3  (funct3),
    .rd      (rd),
    .rs1     (rs1),
    .rs2     (rs2),
    .imm     (imm),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .err     (err),
    .full    (full),
    .rb_err  (rb_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic f, input logic [6:0] op,
                       input logic [2:0] f3, input logic [4:0] d,
                       input logic [4:0] s1, input logic [4:0] s2,
                       input logic [31:0] im);
    fmt = f; opcode = op; funct3 = f3;
    rd = d; rs1 = s1; rs2 = s2; imm = im;
  endtask

  // One request; ea/ed = expected address/word, last = writes final slot.
  task automatic req(input string tag, input logic f,
                     input logic [6:0] op, input logic [2:0] f3,
                     input logic [4:0] d, input logic [4:0] s1,
                     input logic [4:0] s2, input logic [31:0] im,
                     input logic ok, input logic [1:0] ea,
                     input logic [31:0] ed, input logic last);
    int n;
    @(negedge clk);
    drive(f, op, f3, d, s1, s2, im);
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check({tag, "_ready_timeout"}, 32'd0, 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check({tag, "_n1_wr_en"}, {31'd0, wr_en}, 32'd0);
    @(negedge clk);
    if (ok) begin
      check({tag, "_wr_en"}, {31'd0, wr_en}, 32'd1);
      check({tag, "_addr"}, {30'd0, wr_addr}, {30'd0, ea});
      check({tag, "_data"}, wr_data, ed);
      @(negedge clk);
      check({tag, "_n3_wr_en"}, {31'd0, wr_en}, 32'd0);
      check({tag, "_hold"}, wr_data, ed);
      check({tag, "_next_addr"}, {30'd0, wr_addr},
            {30'd0, last ? ea : ea + 2'd1});
      check({tag, "_n3_ready"}, {31'd0, in_ready},
            {31'd0, RB ? 1'b0 : !last});
      if (RB) begin
        @(negedge clk);
        check({tag, "_n4_ready"}, {31'd0, in_ready}, {31'd0, !last});
        check({tag, "_rb_err"}, {31'd0, rb_err}, 32'd0);
      end
    end else begin
      check({tag, "_wr_en"}, {31'd0, wr_en}, 32'd0);
      check({tag, "_err"}, {31'd0, err}, 32'd1);
      check({tag, "_addr"}, {30'd0, wr_addr}, {30'd0, ea});
    end
  endtask

  initial begin
    rst = 1'b1; restart = 1'b0; in_valid = 1'b0;
    drive(1'b0, 7'd0, 3'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {31'd0, in_ready}, 32'd1);
    check("rst_wr_en", {31'd0, wr_en}, 32'd0);
    check("rst_addr", {30'd0, wr_addr}, 32'd0);
    check("rst_data", wr_data, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_full", {31'd0, full}, 32'd0);
    check("rst_rb_err", {31'd0, rb_err}, 32'd0);
    rst = 1'b0;

    req("addi_m1", 1'b0, OP_I, 3'd0, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF,
        1'b1, 2'd0, 32'hFFF0_0093, 1'b0);
    req("bne_m4", 1'b1, OP_B, 3'd1, 5'd0, 5'd1, 5'd0, 32'hFFFF_FFFC,
        1'b1, 2'd1, 32'hFE00_9EE3, 1'b0);
    req("i_2048", 1'b0, OP_I, 3'd0, 5'd1, 5'd0, 5'd0, 32'd2048,
        1'b0, 2'd2, 32'd0, 1'b0);
    req("addi_5", 1'b0, OP_I, 3'd0, 5'd2, 5'd3, 5'd0, 32'd5,
        1'b1, 2'd2, 32'h0051_8113, 1'b0);
    check("err_sticky", {31'd0, err}, 32'd1);
    req("b_4094", 1'b1, OP_B, 3'd1, 5'd0, 5'd1, 5'd2, 32'd4094,
        1'b1, 2'd3, 32'h7E20_9FE3, 1'b1);
    check("full_set", {31'd0, full}, 32'd1);

    // Request while full must be ignored.
    @(negedge clk);
    drive(1'b0, OP_I, 3'd0, 5'd1, 5'd0, 5'd0, 32'd7);
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("full_wr_en", {31'd0, wr_en}, 32'd0);
      check("full_ready", {31'd0, in_ready}, 32'd0);
    end
    check("full_addr", {30'd0, wr_addr}, 32'd3);
    in_valid = 1'b0;
    restart  = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    check("rs_full", {31'd0, full}, 32'd0);
    check("rs_err", {31'd0, err}, 32'd0);
    check("rs_addr", {30'd0, wr_addr}, 32'd0);
    check("rs_ready", {31'd0, in_ready}, 32'd1);

    req("b_odd3", 1'b1, OP_B, 3'd1, 5'd0, 5'd1, 5'd0, 32'd3,
        1'b0, 2'd0, 32'd0, 1'b0);
    req("b_4096", 1'b1, OP_B, 3'd1, 5'd0, 5'd1, 5'd0, 32'd4096,
        1'b0, 2'd0, 32'd0, 1'b0);
    req("b_m4096", 1'b1, OP_B, 3'd0, 5'd0, 5'd0, 5'd0, 32'hFFFF_F000,
        1'b1, 2'd0, 32'h8000_0063, 1'b0);
    req("i_2047", 1'b0, OP_I, 3'd0, 5'd0, 5'd0, 5'd0, 32'd2047,
        1'b1, 2'd1, 32'h7FF0_0013, 1'b0);
    req("i_m2048", 1'b0, OP_I, 3'd0, 5'd0, 5'd0, 5'd0, 32'hFFFF_F800,
        1'b1, 2'd2, 32'h8000_0013, 1'b0);
    req("i_m2049", 1'b0, OP_I, 3'd0, 5'd0, 5'd0, 5'd0, 32'hFFFF_F7FF,
        1'b0, 2'd3, 32'd0, 1'b0);

    // Restart during ENCODE discards the request.
    @(negedge clk);
    drive(1'b0, OP_I, 3'd0, 5'd4, 5'd0, 5'd0, 32'd9);
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    check("rsenc_wr_en", {31'd0, wr_en}, 32'd0);
    check("rsenc_ready", {31'd0, in_ready}, 32'd1);
    check("rsenc_addr", {30'd0, wr_addr}, 32'd0);
    check("rsenc_err", {31'd0, err}, 32'd0);
    @(negedge clk);
    check("rsenc_wr_en2", {31'd0, wr_en}, 32'd0);

    req("addi_again", 1'b0, OP_I, 3'd0, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF,
        1'b1, 2'd0, 32'hFFF0_0093, 1'b0);

    // Reset while in WRITE.
    @(negedge clk);
    drive(1'b0, OP_I, 3'd0, 5'd1, 5'd0, 5'd0, 32'd1);
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rw_wr_en", {31'd0, wr_en}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rw_wr_en_drop", {31'd0, wr_en}, 32'd0);
    @(negedge clk);
    check("rw_addr", {30'd0, wr_addr}, 32'd0);
    check("rw_data", wr_data, 32'd0);
    check("rw_ready", {31'd0, in_ready}, 32'd1);
    check("rw_err", {31'd0, err}, 32'd0);
    check("rw_full", {31'd0, full}, 32'd0);
    check("rw_rb_err", {31'd0, rb_err}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
